// File: rtl/sprite_capture_if.sv
// Pixel-stream and sprite-RAM write signals for sprite_capture.
// master drives the video side and observes the RAM write side; slave is the capture block.
interface sprite_capture_if;
    logic        arm;
    logic        vstart;
    logic        hstart;
    logic        pixel;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        symmetric;

    modport master (
        output arm, vstart, hstart, pixel,
        input  wr_en, wr_addr, wr_data, busy, done, symmetric
    );

    modport slave (
        input  arm, vstart, hstart, pixel,
        output wr_en, wr_addr, wr_data, busy, done, symmetric
    );
endinterface

// File: rtl/sprite_capture.sv
// Samples a 16x16 window of a 1-bit pixel stream and writes it row by row
// into a 16x16-bit sprite RAM, tracking left/right mirror symmetry.
module sprite_capture (
    input  logic             clk,
    input  logic             reset,
    sprite_capture_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_VSTART = 3'd1,
        S_WAIT_HSTART = 3'd2,
        S_SHIFT       = 3'd3,
        S_WRITE       = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_vstart_d;
    logic [3:0]  r_row;
    logic [3:0]  r_col;
    logic [15:0] r_shift;
    logic [15:0] r_wr_data;
    logic [3:0]  r_wr_addr;
    logic        r_sym_acc;
    logic        r_symmetric;

    logic        w_vstart_rise;
    logic [7:0]  w_mirror_eq;
    logic        w_row_sym;

    // Only a true rising edge starts a capture, so arming mid-frame waits a full frame.
    assign w_vstart_rise = bus.vstart & ~r_vstart_d;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mirror
            assign w_mirror_eq[gi] = (r_wr_data[gi] == r_wr_data[15-gi]);
        end
    endgenerate

    assign w_row_sym = &w_mirror_eq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.arm) begin
                    w_state_next = S_WAIT_VSTART;
                end
            end
            S_WAIT_VSTART: begin
                if (w_vstart_rise) begin
                    w_state_next = S_WAIT_HSTART;
                end
            end
            S_WAIT_HSTART: begin
                if (bus.hstart) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_col == 4'd15) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_row == 4'd15) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_WAIT_HSTART;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vstart_d  <= 1'b0;
            r_row       <= 4'd0;
            r_col       <= 4'd0;
            r_shift     <= 16'd0;
            r_wr_data   <= 16'd0;
            r_wr_addr   <= 4'd0;
            r_sym_acc   <= 1'b1;
            r_symmetric <= 1'b0;
        end else begin
            r_vstart_d <= bus.vstart;
            case (r_state)
                S_IDLE: begin
                    r_row     <= 4'd0;
                    r_col     <= 4'd0;
                    r_sym_acc <= 1'b1;
                end
                S_WAIT_HSTART: begin
                    if (bus.hstart) begin
                        r_shift <= {15'd0, bus.pixel};
                        r_col   <= 4'd1;
                    end
                end
                S_SHIFT: begin
                    r_shift[r_col] <= bus.pixel;
                    r_col          <= r_col + 4'd1;
                    // Separate output registers keep wr_addr/wr_data stable between writes.
                    if (r_col == 4'd15) begin
                        r_wr_data <= {bus.pixel, r_shift[14:0]};
                        r_wr_addr <= r_row;
                    end
                end
                S_WRITE: begin
                    r_sym_acc <= r_sym_acc & w_row_sym;
                    if (r_row != 4'd15) begin
                        r_row <= r_row + 4'd1;
                    end
                end
                S_DONE: begin
                    r_symmetric <= r_sym_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.wr_en     = (r_state == S_WRITE);
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.symmetric = r_symmetric;

endmodule

// File: tb/tb_sprite_capture.sv
// Directed bench for sprite_capture on a shrunken video raster
// (40-cycle lines, 20-line frames, window top on line 2).
module tb_sprite_capture;

    localparam int L  = 40;
    localparam int NL = 20;
    localparam int VL = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_capture_if bus_if ();

    sprite_capture dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int hs_cyc = -1000;
    int n_wr = 0;
    int n_done = 0;
    int done_gap = 0;
    int wr_cyc_last = 0;
    logic busy_after_done = 1'b1;
    logic done_prev = 1'b0;
    logic [3:0]  cap_addr [64];
    logic [15:0] cap_data [64];
    int          cap_lat  [64];

    logic [7:0] car [16] = '{8'h00, 8'h0C, 8'hCC, 8'hFC, 8'hEC, 8'hE0, 8'h60, 8'h78,
                             8'h78, 8'h60, 8'hE0, 8'hEC, 8'hFC, 8'hCC, 8'h0C, 8'h00};

    function automatic logic [15:0] exp_word(input int pat, input int row);
        logic [7:0] b;
        logic [15:0] w;
        if (pat == 0) begin
            return row[0] ? 16'h5555 : 16'hAAAA;
        end
        b = car[row];
        w = {8'd0, b};
        for (int j = 0; j < 8; j++) w[8+j] = b[7-j];
        return w;
    endfunction

    function automatic logic pix(input int pat, input int row, input int k);
        if (pat == 0) return logic'((k ^ row) & 1);
        if (k < 8) return car[row][k];
        return car[row][15-k];
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus_if.hstart) hs_cyc = cyc;
        if (bus_if.wr_en) begin
            if (n_wr < 64) begin
                cap_addr[n_wr] = bus_if.wr_addr;
                cap_data[n_wr] = bus_if.wr_data;
                cap_lat[n_wr]  = cyc - hs_cyc;
            end
            n_wr = n_wr + 1;
            wr_cyc_last = cyc;
        end
        if (bus_if.done) begin
            n_done = n_done + 1;
            done_gap = cyc - wr_cyc_last;
        end
        if (done_prev) busy_after_done = bus_if.busy;
        done_prev = bus_if.done;
    end

    task automatic clear_mon();
        n_wr = 0;
        n_done = 0;
        done_gap = 0;
        busy_after_done = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cap_addr[i] = 'x;
            cap_data[i] = 'x;
            cap_lat[i]  = -1;
        end
    endtask

    // One frame: vstart high for all of line VL, hstart at column hpos of every line,
    // window pixels from the pattern, 1 elsewhere; optional single-cycle arm/reset pulses.
    task automatic run_frame(input int pat, input int hpos, input int arm_line, input int arm_col,
                             input int arm2_line, input int arm2_col, input int rst_line, input int rst_col);
        int k;
        int row;
        for (int line = 0; line < NL; line++) begin
            for (int c = 0; c < L; c++) begin
                @(posedge clk);
                #1;
                bus_if.vstart = (line == VL);
                bus_if.hstart = (c == hpos);
                k   = (c >= hpos) ? (c - hpos) : (c + L - hpos);
                row = line - VL - ((c < hpos) ? 1 : 0);
                bus_if.pixel = (row >= 0 && row < 16 && k < 16) ? pix(pat, row, k) : 1'b1;
                bus_if.arm = (line == arm_line && c == arm_col) || (line == arm2_line && c == arm2_col);
                reset = (line == rst_line && c == rst_col);
            end
        end
        @(posedge clk);
        #1;
        bus_if.vstart = 1'b0;
        bus_if.hstart = 1'b0;
        bus_if.pixel  = 1'b0;
        bus_if.arm    = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.arm = 1'b0;
        bus_if.vstart = 1'b0;
        bus_if.hstart = 1'b0;
        bus_if.pixel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus_if.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus_if.wr_en); end
        total++; if (bus_if.wr_addr !== 4'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d want=0", bus_if.wr_addr); end
        total++; if (bus_if.wr_data !== 16'd0) begin bad++; $display("FAIL reset_wr_data got=%h want=0000", bus_if.wr_data); end
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_if.busy); end
        total++; if (bus_if.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus_if.done); end
        total++; if (bus_if.symmetric !== 1'b0) begin bad++; $display("FAIL reset_symmetric got=%b want=0", bus_if.symmetric); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_checker();
        clear_mon();
        @(posedge clk); #1; bus_if.arm = 1'b1;
        @(negedge clk);
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL checker_busy_before_arm got=%b want=0", bus_if.busy); end
        @(posedge clk); #1; bus_if.arm = 1'b0;
        @(negedge clk);
        total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL checker_busy_after_arm got=%b want=1", bus_if.busy); end
        run_frame(0, 10, -1, 0, -1, 0, -1, 0);
        total++; if (n_wr != 16) begin bad++; $display("FAIL checker_nwr got=%0d want=16", n_wr); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap_addr[i] !== 4'(i) || cap_data[i] !== exp_word(0, i) || cap_lat[i] != 16) begin
                bad++;
                $display("FAIL checker_row%0d got addr=%0d data=%h lat=%0d want addr=%0d data=%h lat=16",
                         i, cap_addr[i], cap_data[i], cap_lat[i], i, exp_word(0, i));
            end
        end
        total++; if (n_done != 1 || done_gap != 1) begin bad++; $display("FAIL checker_done got count=%0d gap=%0d want count=1 gap=1", n_done, done_gap); end
        total++; if (busy_after_done !== 1'b0) begin bad++; $display("FAIL checker_busy_after_done got=%b want=0", busy_after_done); end
        total++; if (bus_if.symmetric !== 1'b0) begin bad++; $display("FAIL checker_symmetric got=%b want=0", bus_if.symmetric); end
        total++; if (bus_if.wr_addr !== 4'd15 || bus_if.wr_data !== 16'h5555) begin bad++; $display("FAIL checker_hold got addr=%0d data=%h want addr=15 data=5555", bus_if.wr_addr, bus_if.wr_data); end
    endtask

    task automatic test_car();
        clear_mon();
        run_frame(1, 10, 0, 5, -1, 0, -1, 0);
        total++; if (n_wr != 16) begin bad++; $display("FAIL car_nwr got=%0d want=16", n_wr); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap_addr[i] !== 4'(i) || cap_data[i] !== exp_word(1, i)) begin
                bad++;
                $display("FAIL car_row%0d got addr=%0d data=%h want addr=%0d data=%h",
                         i, cap_addr[i], cap_data[i], i, exp_word(1, i));
            end
        end
        total++; if (n_done != 1) begin bad++; $display("FAIL car_done got=%0d want=1", n_done); end
        total++; if (bus_if.symmetric !== 1'b1) begin bad++; $display("FAIL car_symmetric got=%b want=1", bus_if.symmetric); end
    endtask

    task automatic test_arm_vstart_high();
        clear_mon();
        run_frame(0, 10, VL, 20, -1, 0, -1, 0);
        total++; if (n_wr != 0) begin bad++; $display("FAIL vhigh_first_frame_nwr got=%0d want=0", n_wr); end
        clear_mon();
        run_frame(0, 10, -1, 0, -1, 0, -1, 0);
        total++; if (n_wr != 16) begin bad++; $display("FAIL vhigh_second_frame_nwr got=%0d want=16", n_wr); end
        total++; if (cap_addr[0] !== 4'd0 || cap_data[0] !== 16'hAAAA) begin bad++; $display("FAIL vhigh_row0 got addr=%0d data=%h want addr=0 data=aaaa", cap_addr[0], cap_data[0]); end
        total++; if (cap_data[15] !== 16'h5555 || n_done != 1) begin bad++; $display("FAIL vhigh_row15 got data=%h done=%0d want data=5555 done=1", cap_data[15], n_done); end
    endtask

    task automatic test_arm_on_edge();
        clear_mon();
        run_frame(1, 10, VL, 0, -1, 0, -1, 0);
        total++; if (n_wr != 0) begin bad++; $display("FAIL edge_first_frame_nwr got=%0d want=0", n_wr); end
        clear_mon();
        run_frame(1, 10, -1, 0, -1, 0, -1, 0);
        total++; if (n_wr != 16 || cap_data[3] !== exp_word(1, 3)) begin bad++; $display("FAIL edge_second_frame got nwr=%0d row3=%h want nwr=16 row3=%h", n_wr, cap_data[3], exp_word(1, 3)); end
    endtask

    task automatic test_arm_busy();
        clear_mon();
        run_frame(0, 10, 0, 5, VL + 5, 13, -1, 0);
        total++; if (n_wr != 16) begin bad++; $display("FAIL armbusy_nwr got=%0d want=16", n_wr); end
        total++; if (n_done != 1) begin bad++; $display("FAIL armbusy_done got=%0d want=1", n_done); end
        total++; if (cap_data[5] !== 16'h5555 || cap_addr[6] !== 4'd6) begin bad++; $display("FAIL armbusy_rows got row5=%h addr6=%0d want row5=5555 addr6=6", cap_data[5], cap_addr[6]); end
        clear_mon();
        run_frame(0, 10, -1, 0, -1, 0, -1, 0);
        total++; if (n_wr != 0 || n_done != 0) begin bad++; $display("FAIL armbusy_no_requeue got nwr=%0d done=%0d want 0 0", n_wr, n_done); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        run_frame(0, 10, 0, 5, -1, 0, VL + 7, 28);
        total++; if (n_wr != 8) begin bad++; $display("FAIL rstmid_nwr got=%0d want=8", n_wr); end
        total++; if (cap_addr[7] !== 4'd7 || cap_data[7] !== 16'h5555) begin bad++; $display("FAIL rstmid_row7 got addr=%0d data=%h want addr=7 data=5555", cap_addr[7], cap_data[7]); end
        total++; if (n_done != 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", n_done); end
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus_if.busy); end
        total++; if (bus_if.symmetric !== 1'b0) begin bad++; $display("FAIL rstmid_symmetric got=%b want=0", bus_if.symmetric); end
        clear_mon();
        run_frame(1, 10, 0, 5, -1, 0, -1, 0);
        total++; if (n_wr != 16) begin bad++; $display("FAIL rstmid_recapture_nwr got=%0d want=16", n_wr); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap_addr[i] !== 4'(i) || cap_data[i] !== exp_word(1, i)) begin
                bad++;
                $display("FAIL rstmid_recapture_row%0d got addr=%0d data=%h want addr=%0d data=%h",
                         i, cap_addr[i], cap_data[i], i, exp_word(1, i));
            end
        end
        total++; if (n_done != 1 || bus_if.symmetric !== 1'b1) begin bad++; $display("FAIL rstmid_recapture_done got done=%0d sym=%b want done=1 sym=1", n_done, bus_if.symmetric); end
    endtask

    task automatic test_hblank();
        clear_mon();
        run_frame(0, 30, 0, 5, -1, 0, -1, 0);
        total++; if (n_wr != 16) begin bad++; $display("FAIL hblank_nwr got=%0d want=16", n_wr); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap_addr[i] !== 4'(i) || cap_data[i] !== exp_word(0, i) || cap_lat[i] != 16) begin
                bad++;
                $display("FAIL hblank_row%0d got addr=%0d data=%h lat=%0d want addr=%0d data=%h lat=16",
                         i, cap_addr[i], cap_data[i], cap_lat[i], i, exp_word(0, i));
            end
        end
        total++; if (n_done != 1 || done_gap != 1) begin bad++; $display("FAIL hblank_done got count=%0d gap=%0d want count=1 gap=1", n_done, done_gap); end
    endtask

    initial begin
        test_reset();
        test_checker();
        test_car();
        test_arm_vstart_high();
        test_arm_on_edge();
        test_arm_busy();
        test_reset_mid();
        test_hblank();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
